// File: rtl/div10b5b_seq_if.sv
// Handshake and data bundle for the sequential 10b/5b restoring divider.
// The master side is the controlling FSM. The slave side is the divider.
interface div10b5b_seq_if #(
  parameter int WN = 10,
  parameter int WD = 5
);
  logic          start;
  logic [WN-1:0] z;
  logic [WD-1:0] y;
  logic [WN-1:0] q;
  logic [WD-1:0] r;
  logic          busy;
  logic          done;
  logic          dz;

  modport master (
    output start, z, y,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, z, y,
    output q, r, busy, done, dz
  );
endinterface

// File: rtl/div10b5b_seq.sv
// div10b5b_seq: sequential unsigned restoring divider, z / y -> q, r.
// It produces one quotient bit per clock. The divider accepts a new operation
// in IDLE, and also in FIN so that back-to-back operations are possible.
// A zero divisor skips iteration. It returns q = all ones, r = z[WD-1:0] and
// raises dz.
// Optional build macro: DIV10B5B_EARLY_EXIT_EN. When it is defined, an
// operation with z < y completes on the accepting edge with q = 0 and r = z.
// WN must be >= WD.
module div10b5b_seq #(
  parameter int WN = 10,
  parameter int WD = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  div10b5b_seq_if.slave bus
);

  localparam int CW = (WN > 1) ? $clog2(WN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WN-1:0] dvd_q, dvd_d;     // dividend shifter, fills with quotient bits
  logic [WD:0]   p_q, p_d;         // partial remainder, one spare bit for the compare
  logic [WD-1:0] dsr_q, dsr_d;     // latched divisor
  logic [CW-1:0] cnt_q, cnt_d;     // iterations remaining minus one
  logic [WN-1:0] quo_q, quo_d;
  logic [WD-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept_s;
  logic          early_s;
  logic [WD:0]   p_sh_s;
  logic [WD:0]   p_sub_s;
  logic          qbit_s;
  logic [WN-1:0] dvd_sh_s;

`ifdef DIV10B5B_EARLY_EXIT_EN
  assign early_s = (bus.z < WN'(bus.y));
`else
  assign early_s = 1'b0;
`endif

  // Start is honoured whenever no iteration is in flight (IDLE or FIN).
  assign accept_s = bus.start & (state_q != S_RUN);

  // One restoring step: shift {p, dividend} left, then trial-subtract the divisor.
  always_comb begin
    p_sh_s   = {p_q[WD-1:0], dvd_q[WN-1]};
    qbit_s   = (p_sh_s >= {1'b0, dsr_q});
    if (qbit_s) begin
      p_sub_s = p_sh_s - {1'b0, dsr_q};
    end else begin
      p_sub_s = p_sh_s;
    end
    dvd_sh_s = {dvd_q[WN-2:0], qbit_s};
  end

  // Next-state and datapath update for the IDLE/RUN/FIN controller.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    p_d     = p_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (accept_s) begin
          dsr_d = bus.y;
          if (bus.y == {WD{1'b0}}) begin
            state_d = S_FIN;
            quo_d   = {WN{1'b1}};
            rem_d   = bus.z[WD-1:0];
            dz_d    = 1'b1;
          end else if (early_s) begin
            state_d = S_FIN;
            quo_d   = {WN{1'b0}};
            rem_d   = bus.z[WD-1:0];
            dz_d    = 1'b0;
          end else begin
            state_d = S_RUN;
            dvd_d   = bus.z;
            p_d     = {(WD+1){1'b0}};
            cnt_d   = CW'(WN - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        dvd_d = dvd_sh_s;
        p_d   = p_sub_s;
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {CW{1'b0}}) begin
          // The last iteration publishes the result on this same edge.
          state_d = S_FIN;
          quo_d   = dvd_sh_s;
          rem_d   = p_sub_s[WD-1:0];
          dz_d    = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  // State, datapath and registered outputs. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= {WN{1'b0}};
      p_q     <= {(WD+1){1'b0}};
      dsr_q   <= {WD{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quo_q   <= {WN{1'b0}};
      rem_q   <= {WD{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      p_q     <= p_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = quo_q;
  assign bus.r    = rem_q;
  assign bus.dz   = dz_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_div10b5b_seq.sv
// Self-checking bench for div10b5b_seq. The expected quotient and remainder
// come from plain integer division. The expected latency comes from the
// operand class.
module tb_div10b5b_seq;
  localparam int WN = 10;
  localparam int WD = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [WN-1:0] e_z;
  logic [WD-1:0] e_y;

  div10b5b_seq_if #(.WN(WN), .WD(WD)) bus ();

  div10b5b_seq #(.WN(WN), .WD(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Hard stop if something wedges beyond all per-operation bounds.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive an operation at a negedge. It is accepted on the next rising edge.
  // After that edge the operands are scrambled to show they were latched.
  task automatic issue(input logic [WN-1:0] zz, input logic [WD-1:0] yy);
    bus.start = 1'b1;
    bus.z     = zz;
    bus.y     = yy;
    e_z       = zz;
    e_y       = yy;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.z     = WN'($urandom);
    bus.y     = WD'($urandom);
  endtask

  // Wait for done (bounded) and compare against the reference model.
  // The task returns at the negedge inside the FIN cycle.
  task automatic collect(input string tag);
    int            lat;
    int            busy_cnt;
    int            exp_lat;
    bit            got;
    logic [WN-1:0] eq;
    logic [WD-1:0] er;
    logic          edz;
    if (e_y == '0) begin
      eq      = '1;
      er      = e_z[WD-1:0];
      edz     = 1'b1;
      exp_lat = 1;
    end else begin
      eq      = WN'(e_z / WN'(e_y));
      er      = WD'(e_z % WN'(e_y));
      edz     = 1'b0;
      exp_lat = WN + 1;
`ifdef DIV10B5B_EARLY_EXIT_EN
      if (e_z < WN'(e_y)) exp_lat = 1;
`endif
    end
    lat      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && lat <= 40) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        // A stray start during RUN must be ignored.
        if (lat == 3) begin
          bus.start = 1'b1;
          bus.z     = WN'($urandom);
          bus.y     = WD'($urandom);
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, " done"}, 32'(got), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check_eq({tag, " busy in FIN"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " q"}, 32'(bus.q), 32'(eq));
    check_eq({tag, " r"}, 32'(bus.r), 32'(er));
    check_eq({tag, " dz"}, 32'(bus.dz), 32'(edz));
  endtask

  task automatic op(input string tag, input logic [WN-1:0] zz, input logic [WD-1:0] yy);
    issue(zz, yy);
    collect(tag);
    @(negedge clk);
    check_eq({tag, " done pulse width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.z     = '0;
    bus.y     = '0;
    repeat (3) @(negedge clk);
    check_eq("reset q", 32'(bus.q), 32'd0);
    check_eq("reset r", 32'(bus.r), 32'd0);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    check_eq("reset dz", 32'(bus.dz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op("1023/31", 10'd1023, 5'd31);
    op("100/7", 10'd100, 5'd7);
    op("1023/1", 10'd1023, 5'd1);
    op("0/5", 10'd0, 5'd5);
    op("517/0", 10'd517, 5'd0);
    op("20/3", 10'd20, 5'd3);

    // Back-to-back: the second start is held during the FIN cycle of the first.
    issue(10'd200, 5'd13);
    collect("b2b first");
    issue(10'd50, 5'd9);
    collect("b2b second");
    @(negedge clk);
    check_eq("b2b done pulse width", 32'(bus.done), 32'd0);

    // Reset asserted in RUN cycle 4 aborts the operation.
    issue(10'd300, 5'd11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort q", 32'(bus.q), 32'd0);
    check_eq("abort r", 32'(bus.r), 32'd0);
    check_eq("abort busy", 32'(bus.busy), 32'd0);
    check_eq("abort done", 32'(bus.done), 32'd0);
    check_eq("abort dz", 32'(bus.dz), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("abort no done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post-abort idle busy", 32'(bus.busy), 32'd0);
    op("300/11", 10'd300, 5'd11);

    op("3/20", 10'd3, 5'd20);

    for (int i = 0; i < 16; i++) begin
      logic [WN-1:0] rz;
      logic [WD-1:0] ry;
      rz = WN'($urandom_range(0, 1023));
      case (i % 4)
        0:       ry = WD'($urandom_range(0, 3));
        1:       ry = WD'($urandom_range(20, 31));
        default: ry = WD'($urandom_range(0, 31));
      endcase
      if (i % 5 == 4) rz = WN'($urandom_range(0, 31));
      op("random", rz, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div10b5b_seq.md
Name: div10b5b_seq

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's 5-bit combinational multiplier (product z = x*y).
- Takes a 10-bit dividend z and a 5-bit divisor y. Returns a 10-bit quotient q and a 5-bit remainder r, one quotient bit per clock.
- Used where a product must be reduced back to its factors. Start/busy/done handshake toward the controlling FSM.

Parameters:
- WN, 10, dividend and quotient width
- WD, 5, divisor and remainder width
- Constraint: WN >= WD

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled on a rising edge while busy=0
- z  in  WN  dividend; sampled with start
- y  in  WD  divisor; sampled with start
- q  out  WN  quotient; valid when done=1, held until the next accepted start completes
- r  out  WD  remainder; same validity as q
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when q and r are updated
- dz  out  1  divide-by-zero flag; valid with done, held with q and r

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: q=0, r=0, busy=0, done=0, dz=0, state=IDLE, internal registers=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1.
- start is accepted only when busy=0, i.e. in IDLE or FIN; start during RUN is ignored. Operands are latched on the accepting edge, so later changes to z and y have no effect.
- Accept with y!=0: go to RUN. Load shift register with z, partial remainder p (WD+1 bits) with 0, and counter with WN-1.
- RUN, once per cycle:
  - shift {p, dividend} left by 1;
  - if p >= divisor, then p = p - divisor and shift in quotient bit 1, else shift in 0;
  - decrement the counter.
  - On the counter=0 iteration, write q and r on that same edge and go to FIN.
- Latency: done is high in the cycle after edge WN+1, counting the accepting edge as edge 1 (11 cycles at default).
- FIN lasts 1 cycle, then goes to IDLE, or to RUN if start=1 (back-to-back accept; done still pulses exactly 1 cycle).
- Divide by zero (y=0 at accept): skip RUN and go directly to FIN on the accepting edge. Set q = all ones, r = z[WD-1:0], dz=1.
- dz is cleared on the next accepted start with y!=0, when that operation completes.
- Width rules:
  - r always fits in WD bits because r < y.
  - q covers the full range 0..2^WN-1 (e.g. y=1).
  - p needs WD+1 bits to hold the pre-subtract value; the compare is unsigned.
- rst_n asserted mid-RUN aborts immediately: all outputs return to reset values and no done pulse follows. Releasing reset returns to IDLE.
- q and r do not change except at completion or reset.

Optional Feature:
- Macro: DIV10B5B_EARLY_EXIT_EN
- Defined: at accept, if y!=0 and z < y, skip RUN and go to FIN on the accepting edge with q=0, r=z[WD-1:0], dz=0. Latency is 1 edge.
- Undefined: such operands run the full WN iterations and produce the same q/r (q=0, r=z) at normal latency.

Test Plan:
- Reset, then start with z=1023, y=31 -> after the 11-cycle latency: done pulse, q=33, r=0, dz=0; busy high for exactly 10 cycles.
- z=100, y=7 -> q=14, r=2. Then z=1023, y=1 -> q=1023, r=0. Then z=0, y=5 -> q=0, r=0.
- z=517, y=0 -> done in the cycle after the accepting edge, q=1023, r=5, dz=1. Then z=20, y=3 -> q=6, r=2, dz=0.
- Start pulsed and z/y changed during RUN -> ignored; the result matches the originally latched operands. Start held high in the FIN cycle with z=50, y=9 -> second operation accepted, q=5, r=5, one done pulse per operation.
- rst_n low at cycle 4 of RUN for z=300, y=11 -> q=0, r=0, busy=0, no done. After release, z=300, y=11 -> q=27, r=3.
- z=3, y=20: with DIV10B5B_EARLY_EXIT_EN, done in the cycle after accept, q=0, r=3. Without it, done after 11 cycles with the same q and r.
